// File: rtl/neander_pkg.sv
// Shared opcodes, FSM states and flag bit positions for the Neander accumulator unit.
package neander_pkg;

  localparam logic [3:0] OP_NOP = 4'd0;
  localparam logic [3:0] OP_LDA = 4'd1;
  localparam logic [3:0] OP_ADD = 4'd2;
  localparam logic [3:0] OP_SUB = 4'd3;
  localparam logic [3:0] OP_AND = 4'd4;
  localparam logic [3:0] OP_OR  = 4'd5;
  localparam logic [3:0] OP_NOT = 4'd6;
  localparam logic [3:0] OP_SHL = 4'd7;
  localparam logic [3:0] OP_SHR = 4'd8;
  localparam logic [3:0] OP_MUL = 4'd9;

  typedef enum logic {ST_IDLE, ST_BUSY} state_e;

  localparam int unsigned FLAG_N = 0;
  localparam int unsigned FLAG_Z = 1;
  localparam int unsigned FLAG_C = 2;
  localparam int unsigned FLAG_W = 3;

endpackage

// File: rtl/neander_mul_iter.sv
// Iterative shift-add multiplier: one partial product per cycle for WIDTH cycles.
// Only instantiated when NEANDER_MUL_EN is defined.
module neander_mul_iter #(
  parameter int unsigned WIDTH = 8
) (
  input  logic               clock,
  input  logic               reset_n,
  input  logic               start,
  input  logic               abort,
  input  logic [WIDTH-1:0]   multiplicand,
  input  logic [WIDTH-1:0]   multiplier,
  output logic               done_c,
  output logic [2*WIDTH-1:0] product_c
);

  localparam int unsigned CNTW = $clog2(WIDTH) + 1;

  logic               busy_q, busy_d;
  logic [CNTW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0]   mcand_q, mcand_d;
  logic [2*WIDTH-1:0] prod_q, prod_d;
  logic [WIDTH-1:0]   addend;
  logic [WIDTH:0]     sum;
  logic [2*WIDTH-1:0] step;

  // Low half holds the remaining multiplier bits, high half the running sum.
  always_comb begin
    busy_d  = busy_q;
    cnt_d   = cnt_q;
    mcand_d = mcand_q;
    prod_d  = prod_q;
    done_c  = 1'b0;
    addend  = prod_q[0] ? mcand_q : '0;
    sum     = {1'b0, prod_q[2*WIDTH-1:WIDTH]} + {1'b0, addend};
    step    = {sum, prod_q[WIDTH-1:1]};
    if (abort) begin
      busy_d = 1'b0;
    end else if (start) begin
      busy_d  = 1'b1;
      cnt_d   = '0;
      mcand_d = multiplicand;
      prod_d  = {{WIDTH{1'b0}}, multiplier};
    end else if (busy_q) begin
      prod_d = step;
      cnt_d  = cnt_q + CNTW'(1);
      if (cnt_q == CNTW'(WIDTH - 1)) begin
        busy_d = 1'b0;
        done_c = 1'b1;
      end
    end
    product_c = step;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      busy_q  <= 1'b0;
      cnt_q   <= '0;
      mcand_q <= '0;
      prod_q  <= '0;
    end else begin
      busy_q  <= busy_d;
      cnt_q   <= cnt_d;
      mcand_q <= mcand_d;
      prod_q  <= prod_d;
    end
  end

endmodule

// File: rtl/neander_acc_unit.sv
// Neander accumulator + ALU with N/Z/C flags behind a valid/ready request port.
// Define NEANDER_MUL_EN to add the iterative MUL opcode; otherwise opcode 9 is illegal.
module neander_acc_unit
  import neander_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             acc_clr,
  input  logic             op_valid,
  output logic             op_ready,
  input  logic [3:0]       op_code,
  input  logic [WIDTH-1:0] operand,
  output logic [WIDTH-1:0] acc,
  output logic             flag_n,
  output logic             flag_z,
  output logic             flag_c,
  output logic             done,
  output logic             illegal
);

  logic [WIDTH-1:0]  acc_q, acc_d;
  logic [FLAG_W-1:0] flags_q, flags_d;
  logic              done_q, done_d;
  logic              illegal_q, illegal_d;
  logic [WIDTH:0]    sum_c, diff_c;

`ifdef NEANDER_MUL_EN
  state_e             state_q, state_d;
  logic               mul_start_c;
  logic               mul_done_c;
  logic [2*WIDTH-1:0] mul_product_c;

  neander_mul_iter #(.WIDTH(WIDTH)) u_mul (
    .clock        (clock),
    .reset_n      (reset_n),
    .start        (mul_start_c),
    .abort        (acc_clr),
    .multiplicand (acc_q),
    .multiplier   (operand),
    .done_c       (mul_done_c),
    .product_c    (mul_product_c)
  );

  assign op_ready = (state_q == ST_IDLE);
`else
  assign op_ready = 1'b1;
`endif

  always_comb begin
    acc_d     = acc_q;
    flags_d   = flags_q;
    done_d    = 1'b0;
    illegal_d = 1'b0;
    sum_c     = {1'b0, acc_q} + {1'b0, operand};
    diff_c    = {1'b0, acc_q} - {1'b0, operand};
`ifdef NEANDER_MUL_EN
    state_d     = state_q;
    mul_start_c = 1'b0;
`endif
    if (acc_clr) begin
      acc_d = '0;
`ifdef NEANDER_MUL_EN
      state_d = ST_IDLE;
`endif
    end
`ifdef NEANDER_MUL_EN
    else if (state_q == ST_BUSY) begin
      if (mul_done_c) begin
        acc_d           = mul_product_c[WIDTH-1:0];
        flags_d[FLAG_C] = |mul_product_c[2*WIDTH-1:WIDTH];
        done_d          = 1'b1;
        state_d         = ST_IDLE;
      end
    end
`endif
    else if (op_valid) begin
      done_d = 1'b1;
      case (op_code)
        OP_NOP: begin end
        OP_LDA: acc_d = operand;
        OP_ADD: begin
          acc_d           = sum_c[WIDTH-1:0];
          flags_d[FLAG_C] = sum_c[WIDTH];
        end
        OP_SUB: begin
          acc_d           = diff_c[WIDTH-1:0];
          flags_d[FLAG_C] = diff_c[WIDTH];
        end
        OP_AND: acc_d = acc_q & operand;
        OP_OR:  acc_d = acc_q | operand;
        OP_NOT: acc_d = ~acc_q;
        OP_SHL: begin
          acc_d           = {acc_q[WIDTH-2:0], 1'b0};
          flags_d[FLAG_C] = acc_q[WIDTH-1];
        end
        OP_SHR: begin
          acc_d           = {1'b0, acc_q[WIDTH-1:1]};
          flags_d[FLAG_C] = acc_q[0];
        end
`ifdef NEANDER_MUL_EN
        OP_MUL: begin
          done_d      = 1'b0;
          mul_start_c = 1'b1;
          state_d     = ST_BUSY;
        end
`endif
        default: illegal_d = 1'b1;
      endcase
    end
    // N and Z always track the accumulator value being written.
    flags_d[FLAG_N] = acc_d[WIDTH-1];
    flags_d[FLAG_Z] = (acc_d == '0);
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      acc_q           <= '0;
      flags_q         <= '0;
      flags_q[FLAG_Z] <= 1'b1;
      done_q          <= 1'b0;
      illegal_q       <= 1'b0;
`ifdef NEANDER_MUL_EN
      state_q         <= ST_IDLE;
`endif
    end else begin
      acc_q     <= acc_d;
      flags_q   <= flags_d;
      done_q    <= done_d;
      illegal_q <= illegal_d;
`ifdef NEANDER_MUL_EN
      state_q   <= state_d;
`endif
    end
  end

  assign acc     = acc_q;
  assign flag_n  = flags_q[FLAG_N];
  assign flag_z  = flags_q[FLAG_Z];
  assign flag_c  = flags_q[FLAG_C];
  assign done    = done_q;
  assign illegal = illegal_q;

endmodule
